pixel_sequencer: RTL and testbench
==================================

// Module: pixel_sequencer
// PURPOSE
// - Graphics pixel shifter downstream of bus_access. Consumes pixels_read/char_read
//   from g-access and serialises them into one 4-bit colour per dot.
// - Applies the ECM/BMM/MCM display mode, XSCROLL load alignment and multicolour
//   dot pairing.
// - Feeds the sprite mixer and border stage, with a foreground flag for priority and collision.
// PARAMETERS
// - none (colour width fixed at 4).
// PORTS
// clk_dot4x       in   1   4x dot clock; the only clock
// rst             in   1   synchronous, active-high reset
// dot_rising      in   1   1-of-4 strobe; each pulse is one pixel advance
// xpos_low        in   3   raster x position [2:0] for the current dot
// xscroll         in   3   horizontal fine scroll
// load_en         in   1   display window active; shifter may load
// pixels_read     in   8   g-access bitmap byte
// char_read       in   12  {colour[11:8], char/ptr[7:0]}; 0 when idle
// ecm, bmm, mcm   in   1   display mode bits
// b0c,b1c,b2c,b3c in   4   background colours 0-3
// pixel_color4    out  4   colour of the current dot
// is_foreground   out  1   dot is foreground (priority/collision)
// BEHAVIOUR
// - Reset: shifter=0, char_lat=0, mc_phase=0, pixel_color4=0, is_foreground=0.
// - All state updates only on clk_dot4x edges where dot_rising=1.
// - Outputs are registered and are valid 1 clk_dot4x after the dot_rising edge.
//   They hold until the next dot.
// - Load condition: dot_rising && load_en && xpos_low==xscroll.
//   - shifter<=pixels_read; char_lat<=char_read; mc_phase<=0.
//   - The dot output on a load uses the newly loaded msb(s). Load beats shift.
// - Shift, hires case: ~mc_dot. Shift left 1 bit every dot.
// - Shift, multicolour case: mc_dot = mcm&(bmm|char_lat[11]).
//   - Shift left 2 bits when mc_phase=1; mc_phase toggles every dot.
//   - Each dot pair therefore shows the same 2-bit pixel.
// - Zeros shift in. After 8 dots without a reload, the output is background.
// - Mode decode (ECM,BMM,MCM); b=shifter[7], p=shifter[7:6]:
//   - 000 text: b ? char_lat[11:8] : b0c.
//   - 001 mc text, char_lat[11]=1: p 00=b0c, 01=b1c, 10=b2c, 11={0,char_lat[10:8]}.
//   - 001 mc text, char_lat[11]=0: hires with fg={0,char_lat[10:8]}.
//   - 010 bitmap: b ? char_lat[7:4] : char_lat[3:0].
//   - 011 mc bitmap: p 00=b0c, 01=char_lat[7:4], 10=char_lat[3:0], 11=char_lat[11:8].
//   - 100 ECM text: b ? char_lat[11:8] : b[char_lat[7:6]] (b0c..b3c).
//   - 101, 110, 111 invalid: pixel_color4=0 (black).
//     is_foreground is still computed per the MCM/BMM shift rules.
// - is_foreground: hires: b. Multicolour: p[1] (pairs 10 and 11).
// - Mode or colour-register changes mid-character take effect on the next dot.
//   No re-load is needed.
// - load_en=0: no loads. The shifter keeps shifting out the remaining bits, then 0s.
// - xscroll changing between loads: the next match re-aligns.
//   A char may be cut short or extended (stale zeros).
// - Reset mid-character clears all state on that edge. Output is 0 on the next edge.
// CONFIGURATION
// - SEQ_MODE_DELAY_EN defined:
//   - ecm/bmm/mcm pass through a 1-dot pipeline register, updated on dot_rising.
//     This reproduces the 6569 one-pixel mode-switch lag.
//   - The register resets to 000.
// - SEQ_MODE_DELAY_EN undefined: the mode bits are used directly on the same dot.
// TESTING
// - Reset: rst=1 for 2 clks -> pixel_color4=0 and is_foreground=0.
//   Then dots with load_en=0 -> output b0c, fg=0.
// - Text mode: xscroll=0, pixels_read=8'hA5, char_read=12'h701, b0c=6.
//   -> 8 dots 7,6,7,6,6,7,6,7; fg=1,0,1,0,0,1,0,1.
// - MC text: mcm=1, char_read=12'hE00, pixels_read=8'h1B, b0c=0, b1c=1, b2c=2.
//   -> dot pairs 0,0,1,1,2,2,6,6.
// - MC bitmap: bmm=1, mcm=1, char_read=12'h3C5, pixels_read=8'hE4.
//   -> pairs 3,3,5,5,C,C,0(b0c),0; fg=1,1,1,1,0,0,0,0.
// - Scroll/invalid: xscroll=3 -> first loaded dot appears at xpos_low=3.
//   ecm=bmm=1 -> all dots 0.
//   SEQ_MODE_DELAY_EN: toggling mcm shows the change one dot late.

Source files
------------

// File: rtl/pixel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_sequencer                                              |
// | Description : Graphics pixel shifter. Takes the g-access bitmap byte and   |
// |               character/colour word, aligns the load to XSCROLL, and       |
// |               serialises one 4-bit colour per dot according to the        |
// |               ECM/BMM/MCM display mode (hires or multicolour pairs).       |
// |               Also flags foreground dots for sprite priority/collision.    |
// | Ports       : clk_dot4x       4x dot clock (only clock)                    |
// |               rst             synchronous active-high reset                |
// |               dot_rising      one-in-four strobe, one pulse per dot        |
// |               xpos_low[2:0]   raster x position low bits                   |
// |               xscroll[2:0]    horizontal fine scroll                       |
// |               load_en         display window active (loads allowed)        |
// |               pixels_read[7:0]  bitmap byte                                |
// |               char_read[11:0]   {colour[11:8], char/ptr[7:0]}              |
// |               ecm, bmm, mcm   display mode bits                            |
// |               b0c..b3c[3:0]   background colours 0-3                       |
// |               pixel_color4[3:0] registered dot colour                      |
// |               is_foreground   registered foreground flag                   |
// | Config      : SEQ_MODE_DELAY_EN - when defined, the mode bits pass through |
// |               a one-dot register (6569 mode-switch lag).                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_sequencer (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic        dot_rising,
    input  logic [2:0]  xpos_low,
    input  logic [2:0]  xscroll,
    input  logic        load_en,
    input  logic [7:0]  pixels_read,
    input  logic [11:0] char_read,
    input  logic        ecm,
    input  logic        bmm,
    input  logic        mcm,
    input  logic [3:0]  b0c,
    input  logic [3:0]  b1c,
    input  logic [3:0]  b2c,
    input  logic [3:0]  b3c,
    output logic [3:0]  pixel_color4,
    output logic        is_foreground
);

    // {ecm, bmm, mcm} encodings; anything not listed is an invalid (black) mode
    localparam logic [2:0] c_MODE_TEXT      = 3'b000;
    localparam logic [2:0] c_MODE_MC_TEXT   = 3'b001;
    localparam logic [2:0] c_MODE_BITMAP    = 3'b010;
    localparam logic [2:0] c_MODE_MC_BITMAP = 3'b011;
    localparam logic [2:0] c_MODE_ECM_TEXT  = 3'b100;

    logic [7:0]  r_shifter;
    logic [11:0] r_char_lat;
    logic        r_mc_phase;
    logic [3:0]  r_color;
    logic        r_fg;

    logic        w_load;
    logic [2:0]  w_mode;
    logic [11:0] w_char;
    logic        w_mc_dot;
    logic [7:0]  w_shift;
    logic        w_bit;
    logic [1:0]  w_pair;
    logic [3:0]  w_color;
    logic        w_fg;

`ifdef SEQ_MODE_DELAY_EN
    logic [2:0]  r_mode_dly;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_mode_dly <= 3'b000;
        end else if (dot_rising) begin
            r_mode_dly <= {ecm, bmm, mcm};
        end
    end

    assign w_mode = r_mode_dly;
`else
    assign w_mode = {ecm, bmm, mcm};
`endif

    assign w_load = dot_rising & load_en & (xpos_low == xscroll);

    // On a load dot the freshly fetched word is what gets displayed, so the
    // decode and the multicolour selection both look through to char_read.
    assign w_char   = w_load ? char_read : r_char_lat;
    assign w_mc_dot = w_mode[0] & (w_mode[1] | w_char[11]);

    // Shifter contents that this dot displays. A load shows the new byte's
    // msb(s) immediately; multicolour only advances on every second dot so
    // each 2-bit pixel is held for a dot pair.
    always_comb begin
        w_shift = r_shifter;
        if (w_load) begin
            w_shift = pixels_read;
        end else if (w_mc_dot) begin
            if (r_mc_phase) begin
                w_shift = {r_shifter[5:0], 2'b00};
            end
        end else begin
            w_shift = {r_shifter[6:0], 1'b0};
        end
    end

    assign w_bit  = w_shift[7];
    assign w_pair = w_shift[7:6];
    assign w_fg   = w_mc_dot ? w_pair[1] : w_bit;

    always_comb begin
        w_color = 4'h0;
        case (w_mode)
            c_MODE_TEXT: begin
                w_color = w_bit ? w_char[11:8] : b0c;
            end
            c_MODE_MC_TEXT: begin
                if (w_char[11]) begin
                    case (w_pair)
                        2'b00:   w_color = b0c;
                        2'b01:   w_color = b1c;
                        2'b10:   w_color = b2c;
                        default: w_color = {1'b0, w_char[10:8]};
                    endcase
                end else begin
                    // Colour nibble msb clear selects a hires character
                    w_color = w_bit ? {1'b0, w_char[10:8]} : b0c;
                end
            end
            c_MODE_BITMAP: begin
                w_color = w_bit ? w_char[7:4] : w_char[3:0];
            end
            c_MODE_MC_BITMAP: begin
                case (w_pair)
                    2'b00:   w_color = b0c;
                    2'b01:   w_color = w_char[7:4];
                    2'b10:   w_color = w_char[3:0];
                    default: w_color = w_char[11:8];
                endcase
            end
            c_MODE_ECM_TEXT: begin
                if (w_bit) begin
                    w_color = w_char[11:8];
                end else begin
                    case (w_char[7:6])
                        2'b00:   w_color = b0c;
                        2'b01:   w_color = b1c;
                        2'b10:   w_color = b2c;
                        default: w_color = b3c;
                    endcase
                end
            end
            default: begin
                w_color = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_shifter  <= 8'h00;
            r_char_lat <= 12'h000;
            r_mc_phase <= 1'b0;
            r_color    <= 4'h0;
            r_fg       <= 1'b0;
        end else if (dot_rising) begin
            r_shifter  <= w_shift;
            r_mc_phase <= w_load ? 1'b0 : ~r_mc_phase;
            r_color    <= w_color;
            r_fg       <= w_fg;
            if (w_load) begin
                r_char_lat <= char_read;
            end
        end
    end

    assign pixel_color4  = r_color;
    assign is_foreground = r_fg;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_sequencer                                           |
// | Description : Self-checking bench for pixel_sequencer. Directed mode       |
// |               vectors followed by randomized dots compared against a       |
// |               reference model that indexes the loaded byte by the number   |
// |               of dots since the last load.                                 |
// | Config      : SEQ_MODE_DELAY_EN changes the expected mode-switch timing.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_sequencer;

    logic        clk_dot4x = 1'b0;
    logic        rst = 1'b1;
    logic        dot_rising = 1'b0;
    logic [2:0]  xpos_low = 3'd0;
    logic [2:0]  xscroll = 3'd0;
    logic        load_en = 1'b0;
    logic [7:0]  pixels_read = 8'h00;
    logic [11:0] char_read = 12'h000;
    logic        ecm = 1'b0;
    logic        bmm = 1'b0;
    logic        mcm = 1'b0;
    logic [3:0]  b0c = 4'h0;
    logic [3:0]  b1c = 4'h0;
    logic [3:0]  b2c = 4'h0;
    logic [3:0]  b3c = 4'h0;
    logic [3:0]  pixel_color4;
    logic        is_foreground;

    pixel_sequencer dut (
        .clk_dot4x     (clk_dot4x),
        .rst           (rst),
        .dot_rising    (dot_rising),
        .xpos_low      (xpos_low),
        .xscroll       (xscroll),
        .load_en       (load_en),
        .pixels_read   (pixels_read),
        .char_read     (char_read),
        .ecm           (ecm),
        .bmm           (bmm),
        .mcm           (mcm),
        .b0c           (b0c),
        .b1c           (b1c),
        .b2c           (b2c),
        .b3c           (b3c),
        .pixel_color4  (pixel_color4),
        .is_foreground (is_foreground)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: last loaded byte/word and dots elapsed since load
    logic [7:0]  m_byte;
    logic [11:0] m_char;
    int          m_k;
    logic [2:0]  m_prev_mode;
    logic [2:0]  xpos = 3'd0;

    logic [3:0] exp_text_c  [8] = '{4'h7, 4'h6, 4'h7, 4'h6, 4'h6, 4'h7, 4'h6, 4'h7};
    logic       exp_text_f  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_mct_c   [8] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h6, 4'h6};
    logic       exp_mct_f   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_mcb_c   [8] = '{4'h3, 4'h3, 4'h5, 4'h5, 4'hC, 4'hC, 4'h0, 4'h0};
    logic       exp_mcb_f   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_scr_c   [8] = '{4'h6, 4'h6, 4'h6, 4'h7, 4'h6, 4'h6, 4'h6, 4'h6};
    logic       exp_scr_f   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Colour and foreground of the k-th dot after loading pix/ch in a mode
    function automatic logic [4:0] ref_out(input logic [2:0] mode, input logic [7:0] pix,
                                           input int k, input logic [11:0] ch,
                                           input logic [3:0] c0, input logic [3:0] c1,
                                           input logic [3:0] c2, input logic [3:0] c3);
        logic       mc;
        logic       b;
        logic [1:0] p;
        logic [3:0] col;
        logic [3:0] bg [4];
        bg[0] = c0; bg[1] = c1; bg[2] = c2; bg[3] = c3;
        mc = mode[0] && (mode[1] || ch[11]);
        b  = 1'b0;
        p  = 2'b00;
        if (k < 8) begin
            b = pix[7-k];
            p = pix[7-2*(k/2) -: 2];
        end
        col = 4'h0;
        case (mode)
            3'b000: col = b ? ch[11:8] : c0;
            3'b001: begin
                if (ch[11]) col = (p == 2'b11) ? {1'b0, ch[10:8]} : bg[p];
                else        col = b ? {1'b0, ch[10:8]} : c0;
            end
            3'b010: col = b ? ch[7:4] : ch[3:0];
            3'b011: begin
                case (p)
                    2'b00:   col = c0;
                    2'b01:   col = ch[7:4];
                    2'b10:   col = ch[3:0];
                    default: col = ch[11:8];
                endcase
            end
            3'b100: col = b ? ch[11:8] : bg[ch[7:6]];
            default: col = 4'h0;
        endcase
        return {(mc ? p[1] : b), col};
    endfunction

    // One dot: strobe, advance model, check output, then check it holds
    task automatic dot();
        logic       load;
        logic [2:0] mode_now;
        logic [2:0] mode_used;
        logic [4:0] e;
        xpos_low = xpos;
        load     = load_en && (xpos == xscroll);
        mode_now = {ecm, bmm, mcm};
        dot_rising = 1'b1;
        @(posedge clk_dot4x);
        #1;
        dot_rising = 1'b0;
        if (load) begin
            m_byte = pixels_read;
            m_char = char_read;
            m_k    = 0;
        end else if (m_k < 100) begin
            m_k++;
        end
`ifdef SEQ_MODE_DELAY_EN
        mode_used = m_prev_mode;
`else
        mode_used = mode_now;
`endif
        m_prev_mode = mode_now;
        e = ref_out(mode_used, m_byte, m_k, m_char, b0c, b1c, b2c, b3c);
        check4("model_color", pixel_color4, e[3:0]);
        check1("model_fg", is_foreground, e[4]);
        repeat (3) @(posedge clk_dot4x);
        #1;
        check4("hold_color", pixel_color4, e[3:0]);
        xpos = xpos + 3'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_dot4x);
        #1;
        check4("reset_color", pixel_color4, 4'h0);
        check1("reset_fg", is_foreground, 1'b0);
        rst = 1'b0;
        m_byte = 8'h00;
        m_char = 12'h000;
        m_k = 8;
        m_prev_mode = 3'b000;
    endtask

    // Drain the shifter, switch mode on empty dots, align so next dot is xpos 0
    task automatic flush(input logic [2:0] mode);
        load_en = 1'b0;
        dot();
        dot();
        {ecm, bmm, mcm} = mode;
        dot();
        for (int i = 0; i < 8 && xpos != 3'd0; i++) dot();
    endtask

    initial begin
        @(posedge clk_dot4x);
        #1;
        do_reset();

        // Idle after reset shows background
        b0c = 4'h6; b1c = 4'h1; b2c = 4'h2; b3c = 4'h3;
        for (int i = 0; i < 3; i++) begin
            dot();
            check4("idle_color", pixel_color4, 4'h6);
            check1("idle_fg", is_foreground, 1'b0);
        end

        // Hires text
        flush(3'b000);
        xscroll = 3'd0; pixels_read = 8'hA5; char_read = 12'h701; load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dot();
            check4("text_color", pixel_color4, exp_text_c[i]);
            check1("text_fg", is_foreground, exp_text_f[i]);
        end

        // Multicolour text
        flush(3'b001);
        b0c = 4'h0; b1c = 4'h1; b2c = 4'h2;
        pixels_read = 8'h1B; char_read = 12'hE00; load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dot();
            check4("mctext_color", pixel_color4, exp_mct_c[i]);
            check1("mctext_fg", is_foreground, exp_mct_f[i]);
        end

        // Multicolour bitmap
        flush(3'b011);
        pixels_read = 8'hE4; char_read = 12'h3C5; load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dot();
            check4("mcbmp_color", pixel_color4, exp_mcb_c[i]);
            check1("mcbmp_fg", is_foreground, exp_mcb_f[i]);
        end

        // Fine scroll: load lands on xpos 3
        flush(3'b000);
        b0c = 4'h6; xscroll = 3'd3;
        pixels_read = 8'h80; char_read = 12'h701; load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dot();
            check4("scroll_color", pixel_color4, exp_scr_c[i]);
            check1("scroll_fg", is_foreground, exp_scr_f[i]);
        end

        // Invalid mode ECM+BMM: black, foreground still tracks bits
        flush(3'b110);
        xscroll = 3'd0; pixels_read = 8'hFF; char_read = 12'h701; load_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dot();
            check4("invalid_color", pixel_color4, 4'h0);
            check1("invalid_fg", is_foreground, 1'b1);
        end

        // Mode switch timing on an empty shifter: ECM bg (b0c) vs invalid (0)
        flush(3'b100);
        b0c = 4'h6;
        dot();
        check4("ecm_bg", pixel_color4, 4'h6);
        mcm = 1'b1;
        dot();
`ifdef SEQ_MODE_DELAY_EN
        check4("modesw_on", pixel_color4, 4'h6);
`else
        check4("modesw_on", pixel_color4, 4'h0);
`endif
        dot();
        check4("modesw_on2", pixel_color4, 4'h0);
        mcm = 1'b0;
        dot();
`ifdef SEQ_MODE_DELAY_EN
        check4("modesw_off", pixel_color4, 4'h0);
`else
        check4("modesw_off", pixel_color4, 4'h6);
`endif
        dot();
        check4("modesw_off2", pixel_color4, 4'h6);

        // Randomized dots; mode only changes on a load dot
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) xscroll = 3'($urandom_range(0, 7));
            load_en     = ($urandom_range(0, 7) != 0);
            pixels_read = 8'($urandom);
            char_read   = 12'($urandom);
            if ($urandom_range(0, 7) == 0) b0c = 4'($urandom);
            if ($urandom_range(0, 7) == 0) b1c = 4'($urandom);
            if ($urandom_range(0, 7) == 0) b2c = 4'($urandom);
            if ($urandom_range(0, 7) == 0) b3c = 4'($urandom);
            if (load_en && (xpos == xscroll) && ($urandom_range(0, 2) == 0))
                {ecm, bmm, mcm} = 3'($urandom_range(0, 7));
            dot();
        end

        // Reset in the middle of a character
        {ecm, bmm, mcm} = 3'b000;
        b0c = 4'h9;
        xscroll = xpos; pixels_read = 8'hFF; char_read = 12'h501; load_en = 1'b1;
        dot();
        load_en = 1'b0;
        dot();
        dot();
        do_reset();
        dot();
        check4("post_reset_color", pixel_color4, 4'h9);
        check1("post_reset_fg", is_foreground, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
